player_input_conditioner: RTL and testbench
===========================================

PLAYER_INPUT_CONDITIONER -- requirements
Module: player_input_conditioner

Interface
REQ-001 SHALL be clocked by a single clock and reset by one reset. The reset is asynchronous and active-low.
REQ-002 Parameter INPUT_DEPTH, default 5: number of player buttons; bit indices are K_BUTTON, B_BUTTON, G_BUTTON, WB_BUTTON, WF_BUTTON from params.vh.
REQ-003 Parameter DEBOUNCE_CYCLES, default 250000: number of consecutive stable sys_clk cycles required to accept a level change; legal range 2..2^20-1.
REQ-004 Parameter RAW_ACTIVE_LOW, default 1: when 1, a raw input level of 0 means pressed.
REQ-005 Port sys_clk, input, 1: system clock.
REQ-006 Port reset_n, input, 1: asynchronous active-low reset.
REQ-007 Port raw_buttons, input, INPUT_DEPTH: asynchronous board button levels.
REQ-008 Port frame_tick, input, 1: one-cycle strobe, synchronous to sys_clk, marking a frame boundary.
REQ-009 Port player_buttons, output, INPUT_DEPTH: per-frame button vector, active-high, registered; feeds the next-state calculator.
REQ-010 Port buttons_valid, output, 1: one-cycle pulse in the cycle player_buttons takes a new value.
REQ-011 Port debounced_buttons, output, INPUT_DEPTH: live debounced levels, active-high, for debug.

Function
REQ-012 Each raw bit SHALL pass through a 2-flop synchronizer, then polarity-normalize to active-high per RAW_ACTIVE_LOW.
REQ-013 Each bit SHALL have an independent 4-state debounce FSM:
- RELEASED -> PRESS_WAIT on synchronized 1.
- PRESS_WAIT -> PRESSED after DEBOUNCE_CYCLES consecutive 1s.
- PRESS_WAIT -> RELEASED on any 0.
- PRESSED -> RELEASE_WAIT on 0.
- RELEASE_WAIT -> RELEASED after DEBOUNCE_CYCLES consecutive 0s.
- RELEASE_WAIT -> PRESSED on any 1.
REQ-014 debounced_buttons[i] SHALL be 1 in the PRESSED and RELEASE_WAIT states and 0 otherwise.
REQ-015 The debounce counter SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits wide, SHALL clear on every FSM transition, and SHALL never wrap.
REQ-016 Latency from a clean raw edge to the debounced_buttons change SHALL be exactly 2+DEBOUNCE_CYCLES sys_clk cycles.
REQ-017 A per-bit sticky press latch SHALL set on the RELEASED->PRESSED debounced transition, so a press-and-release inside one frame is not lost.
REQ-018 On frame_tick=1, player_buttons SHALL load (debounced_buttons | sticky) in the next cycle, buttons_valid SHALL pulse that cycle, and all sticky bits SHALL clear.
REQ-019 If a sticky set and frame_tick coincide in the same cycle, that press SHALL be included in the load, and the sticky bit SHALL end up cleared.
REQ-020 Between frame_ticks, player_buttons SHALL hold its value.
REQ-021 frame_tick asserted on consecutive cycles SHALL cause a load every cycle, with no error.

Reset
REQ-022 Asserting reset_n low SHALL immediately set:
- synchronizers to the released level;
- all FSMs to RELEASED and all counters to 0;
- sticky, player_buttons, debounced_buttons to 0;
- buttons_valid to 0.
REQ-023 A reset asserted mid-debounce or mid-frame SHALL discard all pending presses. The first load after release SHALL reflect only presses debounced after the release.

Configuration
REQ-024 Macro INPUT_SOCD_CLEAN_EN, when defined, SHALL clear both WB_BUTTON and WF_BUTTON in the value loaded into player_buttons if both are 1. Other bits and debounced_buttons SHALL be unaffected.
REQ-025 Without INPUT_SOCD_CLEAN_EN, both bits SHALL pass through unmodified, leaving priority to the downstream stage.

Verification (DEBOUNCE_CYCLES=4, RAW_ACTIVE_LOW=1, INPUT_DEPTH=5)
REQ-026 Scenario 1, clean press: raw K bit goes 1->0 and is held. Required: debounced K rises exactly 6 cycles later; the next frame_tick yields player_buttons[K]=1 with buttons_valid=1 for one cycle.
REQ-027 Scenario 2, bounce: raw K bit toggles every 2 cycles for 20 cycles, then settles at 1 (released). Required: debounced_buttons stays 0 throughout; player_buttons stays 0.
REQ-028 Scenario 3, short tap: raw G held low for 8 cycles entirely between two frame_ticks spaced 40 cycles apart. Required: second frame_tick loads player_buttons[G]=1; the following frame_tick loads 0.
REQ-029 Scenario 4, coincident edge: sticky set and frame_tick in the same cycle. Required: the load includes the bit, and the next frame loads 0 if the button is released.
REQ-030 Scenario 5, SOCD: WB and WF both held. Required: player_buttons[WB]=[WF]=0 with INPUT_SOCD_CLEAN_EN defined; both 1 without it.
REQ-031 Scenario 6, mid-operation reset: reset_n pulsed low while K is in PRESS_WAIT and another bit's sticky is set. Required: all outputs 0 immediately; the next frame_tick after release loads 5'b00000.

Source files
------------

// File: rtl/player_input_conditioner_if.sv
// rtl/player_input_conditioner_if.sv - button conditioner signal bundle
interface player_input_conditioner_if #(
  parameter int INPUT_DEPTH = 5
);
  logic [INPUT_DEPTH-1:0] raw_buttons;
  logic                   frame_tick;
  logic [INPUT_DEPTH-1:0] player_buttons;
  logic                   buttons_valid;
  logic [INPUT_DEPTH-1:0] debounced_buttons;

  modport master (
    output raw_buttons,
    output frame_tick,
    input  player_buttons,
    input  buttons_valid,
    input  debounced_buttons
  );

  modport slave (
    input  raw_buttons,
    input  frame_tick,
    output player_buttons,
    output buttons_valid,
    output debounced_buttons
  );
endinterface

// File: rtl/player_input_conditioner.sv
// rtl/player_input_conditioner.sv - synchronize, debounce and frame-latch player buttons (optional INPUT_SOCD_CLEAN_EN)
module player_input_conditioner #(
  parameter int INPUT_DEPTH     = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input logic                       sys_clk,
  input logic                       reset_n,
  player_input_conditioner_if.slave bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // PRESS_WAIT/RELEASE_WAIT are entered on the first qualifying sample,
  // so the wait state only needs DEBOUNCE_CYCLES-1 more samples.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [INPUT_DEPTH-1:0] RAW_RELEASED = {INPUT_DEPTH{RAW_ACTIVE_LOW != 0}};

`ifdef INPUT_SOCD_CLEAN_EN
  localparam int WB_BUTTON = 3;
  localparam int WF_BUTTON = 4;
`endif

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } db_state_e;

  logic [INPUT_DEPTH-1:0] sync1_q, sync1_d;
  logic [INPUT_DEPTH-1:0] sync2_q, sync2_d;
  logic [INPUT_DEPTH-1:0] pressed_in;

  db_state_e              state_q [INPUT_DEPTH];
  db_state_e              state_d [INPUT_DEPTH];
  logic [CNT_W-1:0]       cnt_q   [INPUT_DEPTH];
  logic [CNT_W-1:0]       cnt_d   [INPUT_DEPTH];
  logic [INPUT_DEPTH-1:0] rise;

  logic [INPUT_DEPTH-1:0] debounced_q, debounced_d;
  logic [INPUT_DEPTH-1:0] sticky_q, sticky_d;
  logic [INPUT_DEPTH-1:0] player_buttons_q, player_buttons_d;
  logic                   buttons_valid_q, buttons_valid_d;
  logic [INPUT_DEPTH-1:0] load_val;

  // Two-flop synchronizer followed by normalization to active-high.
  always_comb begin
    sync1_d    = bus.raw_buttons;
    sync2_d    = sync1_q;
    pressed_in = (RAW_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  end

  // Per-bit debounce FSM; counter clears on every state change and saturates at CNT_LAST.
  always_comb begin
    for (int i = 0; i < INPUT_DEPTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      rise[i]    = 1'b0;
      case (state_q[i])
        ST_RELEASED: begin
          if (pressed_in[i]) state_d[i] = ST_PRESS_WAIT;
        end
        ST_PRESS_WAIT: begin
          if (!pressed_in[i]) begin
            state_d[i] = ST_RELEASED;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_PRESSED;
            rise[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!pressed_in[i]) state_d[i] = ST_RELEASE_WAIT;
        end
        ST_RELEASE_WAIT: begin
          if (pressed_in[i]) begin
            state_d[i] = ST_PRESSED;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_RELEASED;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = ST_RELEASED;
      endcase
      debounced_d[i] = (state_d[i] == ST_PRESSED) || (state_d[i] == ST_RELEASE_WAIT);
    end
  end

  // Frame load: a press debouncing in the tick cycle is folded in via rise, so it is never lost.
  always_comb begin
    load_val = debounced_q | sticky_q | rise;
`ifdef INPUT_SOCD_CLEAN_EN
    if (load_val[WB_BUTTON] && load_val[WF_BUTTON]) begin
      load_val[WB_BUTTON] = 1'b0;
      load_val[WF_BUTTON] = 1'b0;
    end
`endif
    player_buttons_d = bus.frame_tick ? load_val : player_buttons_q;
    buttons_valid_d  = bus.frame_tick;
    sticky_d         = bus.frame_tick ? '0 : (sticky_q | rise);
  end

  // State registers; reset drops every pending press.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q          <= RAW_RELEASED;
      sync2_q          <= RAW_RELEASED;
      debounced_q      <= '0;
      sticky_q         <= '0;
      player_buttons_q <= '0;
      buttons_valid_q  <= 1'b0;
      for (int i = 0; i < INPUT_DEPTH; i++) begin
        state_q[i] <= ST_RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q          <= sync1_d;
      sync2_q          <= sync2_d;
      debounced_q      <= debounced_d;
      sticky_q         <= sticky_d;
      player_buttons_q <= player_buttons_d;
      buttons_valid_q  <= buttons_valid_d;
      for (int i = 0; i < INPUT_DEPTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.player_buttons    = player_buttons_q;
  assign bus.buttons_valid     = buttons_valid_q;
  assign bus.debounced_buttons = debounced_q;
endmodule

// File: tb/tb_player_input_conditioner.sv
// tb/tb_player_input_conditioner.sv - directed self-checking bench for player_input_conditioner
module tb_player_input_conditioner;
  localparam int K  = 0;
  localparam int B  = 1;
  localparam int G  = 2;
  localparam int WB = 3;
  localparam int WF = 4;
  localparam logic [4:0] IDLE = 5'b11111;

  logic sys_clk;
  logic reset_n;
  int   checks;
  int   errors;

  player_input_conditioner_if #(.INPUT_DEPTH(5)) bus ();

  player_input_conditioner #(
    .INPUT_DEPTH    (5),
    .DEBOUNCE_CYCLES(4),
    .RAW_ACTIVE_LOW (1)
  ) dut (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic frame(input string tag, input logic [4:0] exp_pb);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    chk({tag, "_pb"}, {3'b0, bus.player_buttons}, {3'b0, exp_pb});
    chk({tag, "_valid"}, {7'b0, bus.buttons_valid}, 8'd1);
    step();
    chk({tag, "_valid_clr"}, {7'b0, bus.buttons_valid}, 8'd0);
    chk({tag, "_hold"}, {3'b0, bus.player_buttons}, {3'b0, exp_pb});
  endtask

  initial begin
    logic [4:0] socd_exp;
    logic [4:0] socd_k_exp;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.raw_buttons = IDLE;
    bus.frame_tick = 1'b0;

    // Reset state
    steps(3);
    chk("rst_deb", {3'b0, bus.debounced_buttons}, 8'd0);
    chk("rst_pb", {3'b0, bus.player_buttons}, 8'd0);
    chk("rst_valid", {7'b0, bus.buttons_valid}, 8'd0);
    reset_n = 1'b1;
    steps(2);
    frame("idle", 5'b00000);

    // Scenario 1: clean press, 6-cycle latency
    bus.raw_buttons[K] = 1'b0;
    steps(5);
    chk("s1_deb_c5", {3'b0, bus.debounced_buttons}, 8'd0);
    step();
    chk("s1_deb_c6", {3'b0, bus.debounced_buttons}, 8'b00001);
    steps(3);
    frame("s1", 5'b00001);
    bus.raw_buttons = IDLE;
    steps(5);
    chk("s1_rel_c5", {3'b0, bus.debounced_buttons}, 8'b00001);
    step();
    chk("s1_rel_c6", {3'b0, bus.debounced_buttons}, 8'd0);
    frame("s1_rel", 5'b00000);

    // Scenario 2: bounce never debounces
    for (int c = 0; c < 20; c++) begin
      bus.raw_buttons[K] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      chk("s2_bounce_deb", {3'b0, bus.debounced_buttons}, 8'd0);
    end
    bus.raw_buttons = IDLE;
    steps(8);
    chk("s2_settle_deb", {3'b0, bus.debounced_buttons}, 8'd0);
    frame("s2", 5'b00000);

    // Scenario 3: short tap of G between frames
    frame("s3_a", 5'b00000);
    steps(2);
    bus.raw_buttons[G] = 1'b0;
    steps(6);
    chk("s3_tap_deb", {3'b0, bus.debounced_buttons}, 8'b00100);
    steps(2);
    bus.raw_buttons = IDLE;
    steps(6);
    chk("s3_tap_rel", {3'b0, bus.debounced_buttons}, 8'd0);
    steps(22);
    frame("s3_b", 5'b00100);
    steps(38);
    frame("s3_c", 5'b00000);

    // Scenario 4: sticky set coincides with frame_tick
    bus.raw_buttons[B] = 1'b0;
    steps(5);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    chk("s4_pb", {3'b0, bus.player_buttons}, 8'b00010);
    chk("s4_valid", {7'b0, bus.buttons_valid}, 8'd1);
    chk("s4_deb", {3'b0, bus.debounced_buttons}, 8'b00010);
    bus.raw_buttons = IDLE;
    steps(6);
    chk("s4_rel_deb", {3'b0, bus.debounced_buttons}, 8'd0);
    frame("s4_next", 5'b00000);

    // Back-to-back frame ticks load every cycle
    bus.raw_buttons[K] = 1'b0;
    steps(6);
    chk("bb_deb", {3'b0, bus.debounced_buttons}, 8'b00001);
    bus.frame_tick = 1'b1;
    step();
    chk("bb_v1", {7'b0, bus.buttons_valid}, 8'd1);
    chk("bb_pb1", {3'b0, bus.player_buttons}, 8'b00001);
    step();
    chk("bb_v2", {7'b0, bus.buttons_valid}, 8'd1);
    bus.raw_buttons = IDLE;
    step();
    chk("bb_v3", {7'b0, bus.buttons_valid}, 8'd1);
    chk("bb_pb3", {3'b0, bus.player_buttons}, 8'b00001);
    bus.frame_tick = 1'b0;
    step();
    chk("bb_v_clr", {7'b0, bus.buttons_valid}, 8'd0);
    steps(3);
    chk("bb_rel_c5", {3'b0, bus.debounced_buttons}, 8'b00001);
    step();
    chk("bb_rel_c6", {3'b0, bus.debounced_buttons}, 8'd0);
    frame("bb_after", 5'b00000);

    // Scenario 5: SOCD pair, then with K held too
`ifdef INPUT_SOCD_CLEAN_EN
    socd_exp   = 5'b00000;
    socd_k_exp = 5'b00001;
`else
    socd_exp   = 5'b11000;
    socd_k_exp = 5'b11001;
`endif
    bus.raw_buttons[WB] = 1'b0;
    bus.raw_buttons[WF] = 1'b0;
    steps(6);
    chk("s5_deb", {3'b0, bus.debounced_buttons}, 8'b11000);
    frame("s5", socd_exp);
    bus.raw_buttons[K] = 1'b0;
    steps(6);
    chk("s5k_deb", {3'b0, bus.debounced_buttons}, 8'b11001);
    frame("s5k", socd_k_exp);
    bus.raw_buttons = IDLE;
    steps(6);
    frame("s5_rel", 5'b00000);

    // Scenario 6: reset mid-debounce with a pending sticky
    bus.raw_buttons[G] = 1'b0;
    steps(6);
    frame("s6_g", 5'b00100);
    bus.raw_buttons = IDLE;
    bus.raw_buttons[B] = 1'b0;
    steps(6);
    chk("s6_b_deb", {3'b0, bus.debounced_buttons}, 8'b00010);
    bus.raw_buttons = IDLE;
    steps(6);
    chk("s6_b_rel", {3'b0, bus.debounced_buttons}, 8'd0);
    chk("s6_pb_held", {3'b0, bus.player_buttons}, 8'b00100);
    bus.raw_buttons[K] = 1'b0;
    steps(3);
    reset_n = 1'b0;
    bus.raw_buttons = IDLE;
    #1;
    chk("s6_rst_deb", {3'b0, bus.debounced_buttons}, 8'd0);
    chk("s6_rst_pb", {3'b0, bus.player_buttons}, 8'd0);
    chk("s6_rst_valid", {7'b0, bus.buttons_valid}, 8'd0);
    steps(2);
    reset_n = 1'b1;
    steps(3);
    frame("s6_post", 5'b00000);
    bus.raw_buttons[K] = 1'b0;
    steps(6);
    frame("s6_new", 5'b00001);
    bus.raw_buttons = IDLE;
    steps(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
